// File: rtl/unencoded_ternary_cam_pkg.sv
// Shared definitions for the unencoded ternary CAM.
// Contents:
//   DEFAULT_CMP_WIDTH / DEFAULT_DEPTH  default geometry
//   WRITE_CYCLES_MIN / _MAX            legal write-latency range
//   WR_CNT_BITS                        width of the write-latency counter
//   wr_state_e                         write FSM states
//   log2()                             ceiling log2, never less than 1
//   write_cycles_ok()                  write-latency range check
package unencoded_ternary_cam_pkg;

    localparam int DEFAULT_CMP_WIDTH = 32;
    localparam int DEFAULT_DEPTH     = 32;
    localparam int WRITE_CYCLES_MIN  = 1;
    localparam int WRITE_CYCLES_MAX  = 15;
    localparam int WR_CNT_BITS       = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WRITING = 1'b1
    } wr_state_e;

    // Ceiling log2 with a floor of 1 so a 1-entry CAM still gets an address bit.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit write_cycles_ok(input int w);
        return (w >= WRITE_CYCLES_MIN) && (w <= WRITE_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/unencoded_ternary_cam_cmp.sv
// Single ternary entry compare.
// Ports:
//   stored_data  entry data
//   stored_mask  entry don't-care mask (1 = ignore bit)
//   valid        entry holds a committed write
//   key          compare key
//   key_mask     key don't-care mask (1 = ignore bit)
//   hit          entry matches the key
module cam_entry_cmp #(
    parameter int CMP_WIDTH = 32
) (
    input  logic [CMP_WIDTH-1:0] stored_data,
    input  logic [CMP_WIDTH-1:0] stored_mask,
    input  logic                 valid,
    input  logic [CMP_WIDTH-1:0] key,
    input  logic [CMP_WIDTH-1:0] key_mask,
    output logic                 hit
);

    // A bit agrees when it is equal or ignored by either mask.
    assign hit = valid & (&(~(stored_data ^ key) | stored_mask | key_mask));

endmodule

// File: rtl/unencoded_ternary_cam.sv
// Register-based ternary CAM with an unencoded multi-match result.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   cmp_din        compare key, sampled every edge
//   cmp_data_mask  key don't-care mask (1 = ignore bit)
//   din            entry data to write
//   data_mask      entry don't-care mask to write (1 = ignore bit)
//   we             write strobe, sampled every edge
//   wr_addr        entry index to write
//   busy           write in progress; new writes are dropped
//   match          OR of match_addr
//   match_addr     one bit per entry, registered one edge after the key
//   wr_err         sticky: a write was dropped (busy or address out of range)
//
// Write handshake: a write is accepted on an edge where we=1, busy=0 and
// wr_addr<DEPTH. With WRITE_CYCLES=1 it commits on that same edge and busy
// never rises. Otherwise busy is high for WRITE_CYCLES-1 cycles and the
// commit happens on the edge where busy falls. Any we=1 that is not
// accepted is dropped and sets wr_err.
module unencoded_ternary_cam
    import unencoded_ternary_cam_pkg::*;
#(
    parameter int CMP_WIDTH    = DEFAULT_CMP_WIDTH,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int DEPTH_BITS   = log2(DEPTH),
    parameter int WRITE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CMP_WIDTH-1:0]  cmp_din,
    input  logic [CMP_WIDTH-1:0]  cmp_data_mask,
    input  logic [CMP_WIDTH-1:0]  din,
    input  logic [CMP_WIDTH-1:0]  data_mask,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] wr_addr,
    output logic                  busy,
    output logic                  match,
    output logic [DEPTH-1:0]      match_addr,
    output logic                  wr_err
);

    if (!write_cycles_ok(WRITE_CYCLES)) begin : g_bad_write_cycles
        $error("unencoded_ternary_cam: WRITE_CYCLES out of range");
    end

    localparam logic [DEPTH_BITS:0]    ADDR_LIMIT = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [WR_CNT_BITS-1:0] CNT_LOAD   = WR_CNT_BITS'(WRITE_CYCLES - 1);
    localparam logic [WR_CNT_BITS-1:0] CNT_ONE    = WR_CNT_BITS'(1);

    // Write FSM state; state_q is the observable write state.
    wr_state_e               state_q, state_d;
    logic [WR_CNT_BITS-1:0]  cnt_q, cnt_d;

    // Entry storage; contents are deliberately not reset, valid_q gates them.
    logic [CMP_WIDTH-1:0]    data_mem [DEPTH];
    logic [CMP_WIDTH-1:0]    mask_mem [DEPTH];
    logic [DEPTH-1:0]        valid_q;

    // Staged write for multi-cycle commits.
    logic [DEPTH_BITS-1:0]   stg_addr;
    logic [CMP_WIDTH-1:0]    stg_data;
    logic [CMP_WIDTH-1:0]    stg_mask;

    logic [DEPTH-1:0]        match_addr_q;
    logic                    match_q;
    logic                    wr_err_q;

    logic                    addr_ok;
    logic                    accept;
    logic                    commit;
    logic                    drop;
    logic [DEPTH_BITS-1:0]   commit_addr;
    logic [CMP_WIDTH-1:0]    commit_data;
    logic [CMP_WIDTH-1:0]    commit_mask;
    logic [DEPTH-1:0]        hit;

    assign addr_ok = ({1'b0, wr_addr} < ADDR_LIMIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        commit      = 1'b0;
        drop        = 1'b0;
        commit_addr = stg_addr;
        commit_data = stg_data;
        commit_mask = stg_mask;
        case (state_q)
            ST_IDLE: begin
                if (we) begin
                    if (addr_ok) begin
                        accept = 1'b1;
                        if (WRITE_CYCLES == 1) begin
                            // Single-cycle write bypasses staging entirely.
                            commit      = 1'b1;
                            commit_addr = wr_addr;
                            commit_data = din;
                            commit_mask = data_mask;
                        end else begin
                            state_d = ST_WRITING;
                            cnt_d   = CNT_LOAD;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_WRITING: begin
                if (we) drop = 1'b1;
                cnt_d = cnt_q - CNT_ONE;
                // Last busy cycle: commit and release on this edge.
                if (cnt_q == CNT_ONE) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        cam_entry_cmp #(
            .CMP_WIDTH (CMP_WIDTH)
        ) u_cmp (
            .stored_data (data_mem[i]),
            .stored_mask (mask_mem[i]),
            .valid       (valid_q[i]),
            .key         (cmp_din),
            .key_mask    (cmp_data_mask),
            .hit         (hit[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            valid_q      <= '0;
            match_addr_q <= '0;
            match_q      <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            // hit uses pre-edge storage, so a compare on the commit edge sees old contents.
            match_addr_q <= hit;
            match_q      <= |hit;
            if (drop)   wr_err_q             <= 1'b1;
            if (commit) valid_q[commit_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            stg_addr <= wr_addr;
            stg_data <= din;
            stg_mask <= data_mask;
        end
        if (commit) begin
            data_mem[commit_addr] <= commit_data;
            mask_mem[commit_addr] <= commit_mask;
        end
    end

    assign busy       = (state_q == ST_WRITING);
    assign match      = match_q;
    assign match_addr = match_addr_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_unencoded_ternary_cam.sv
module tb_unencoded_ternary_cam;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: 32 entries, single-cycle write ----------------
    logic [31:0] a_cmp_din, a_cmp_mask, a_din, a_dmask;
    logic        a_we;
    logic [4:0]  a_wr_addr;
    logic        a_busy, a_match, a_wr_err;
    logic [31:0] a_match_addr;

    unencoded_ternary_cam #(
        .CMP_WIDTH    (32),
        .DEPTH        (32),
        .WRITE_CYCLES (1)
    ) u_dut_a (
        .clk           (clk),
        .reset         (rst),
        .cmp_din       (a_cmp_din),
        .cmp_data_mask (a_cmp_mask),
        .din           (a_din),
        .data_mask     (a_dmask),
        .we            (a_we),
        .wr_addr       (a_wr_addr),
        .busy          (a_busy),
        .match         (a_match),
        .match_addr    (a_match_addr),
        .wr_err        (a_wr_err)
    );

    // ---------------- DUT B: 20 entries, three-cycle write ----------------
    logic [31:0] b_cmp_din, b_cmp_mask, b_din, b_dmask;
    logic        b_we;
    logic [4:0]  b_wr_addr;
    logic        b_busy, b_match, b_wr_err;
    logic [19:0] b_match_addr;

    unencoded_ternary_cam #(
        .CMP_WIDTH    (32),
        .DEPTH        (20),
        .WRITE_CYCLES (3)
    ) u_dut_b (
        .clk           (clk),
        .reset         (rst),
        .cmp_din       (b_cmp_din),
        .cmp_data_mask (b_cmp_mask),
        .din           (b_din),
        .data_mask     (b_dmask),
        .we            (b_we),
        .wr_addr       (b_wr_addr),
        .busy          (b_busy),
        .match         (b_match),
        .match_addr    (b_match_addr),
        .wr_err        (b_wr_err)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_b_q[$];
    int vectors;
    int miscompares;

    // Reference contents of DUT A.
    logic [31:0] m_data  [32];
    logic [31:0] m_mask  [32];
    logic        m_valid [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_vec(input logic [31:0] key, input logic [31:0] kmask);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            if (m_valid[i] && (((m_data[i] ^ key) & ~m_mask[i] & ~kmask) == 32'h0)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // All inputs change and all outputs are sampled 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    endtask

    task automatic a_pop_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got empty scoreboard expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_vec"}, a_match_addr, e);
            check({tag, "_flag"}, {31'b0, a_match}, {31'b0, |e});
        end
    endtask

    task automatic b_pop_check(input string tag);
        logic [31:0] e;
        if (exp_b_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got empty scoreboard expected entry", tag);
        end else begin
            e = exp_b_q.pop_front();
            check({tag, "_vec"}, {12'b0, b_match_addr}, e);
            check({tag, "_flag"}, {31'b0, b_match}, {31'b0, |e});
        end
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] mask);
        a_we = 1'b1; a_wr_addr = addr; a_din = data; a_dmask = mask;
        step();
        a_we = 1'b0;
        m_data[addr] = data; m_mask[addr] = mask; m_valid[addr] = 1'b1;
    endtask

    task automatic a_lookup(input string tag, input logic [31:0] key, input logic [31:0] kmask,
                            input logic [31:0] exp);
        a_cmp_din = key; a_cmp_mask = kmask;
        exp_q.push_back(exp);
        step();
        a_pop_check(tag);
    endtask

    task automatic b_write(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] mask);
        b_we = 1'b1; b_wr_addr = addr; b_din = data; b_dmask = mask;
        step();
        b_we = 1'b0;
    endtask

    task automatic b_lookup(input string tag, input logic [31:0] key, input logic [31:0] kmask,
                            input logic [31:0] exp);
        b_cmp_din = key; b_cmp_mask = kmask;
        exp_b_q.push_back(exp);
        step();
        b_pop_check(tag);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] key, kmask;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        a_cmp_din = '0; a_cmp_mask = '0; a_din = '0; a_dmask = '0; a_we = 1'b0; a_wr_addr = '0;
        b_cmp_din = '0; b_cmp_mask = '0; b_din = '0; b_dmask = '0; b_we = 1'b0; b_wr_addr = '0;
        for (int i = 0; i < 32; i++) begin
            m_data[i] = '0; m_mask[i] = '0; m_valid[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_a_vec",   a_match_addr, 32'h0);
        check("rst_a_match", {31'b0, a_match}, 32'h0);
        check("rst_a_busy",  {31'b0, a_busy}, 32'h0);
        check("rst_a_err",   {31'b0, a_wr_err}, 32'h0);
        check("rst_b_busy",  {31'b0, b_busy}, 32'h0);
        rst = 1'b0;

        a_lookup("empty_a", 32'h0, 32'h0, 32'h0);
        b_lookup("empty_b", 32'h0, 32'h0, 32'h0);

        // B: out-of-range address is dropped and flagged.
        b_write(5'd25, 32'h77, 32'h0);
        check("oor_busy", {31'b0, b_busy}, 32'h0);
        check("oor_err",  {31'b0, b_wr_err}, 32'h1);
        repeat (3) step();
        b_lookup("oor_key",  32'h77, 32'h0, 32'h0);
        b_lookup("oor_any",  32'h0, 32'hFFFF_FFFF, 32'h0);

        do_reset();
        check("err_cleared", {31'b0, b_wr_err}, 32'h0);

        // B: multi-cycle write with a write attempted while busy.
        b_we = 1'b1; b_wr_addr = 5'd0; b_din = 32'h55; b_dmask = 32'h0;
        step();
        check("wc_busy0", {31'b0, b_busy}, 32'h1);
        check("wc_err0",  {31'b0, b_wr_err}, 32'h0);
        b_wr_addr = 5'd1; b_din = 32'h66;
        step();
        check("wc_busy1", {31'b0, b_busy}, 32'h1);
        check("wc_err1",  {31'b0, b_wr_err}, 32'h1);
        b_we = 1'b0;
        b_cmp_din = 32'h55; b_cmp_mask = 32'h0;
        exp_b_q.push_back(32'h0);
        step();
        check("wc_busy2", {31'b0, b_busy}, 32'h0);
        b_pop_check("commit_edge");
        b_lookup("after_commit", 32'h55, 32'h0, 32'h1);
        b_lookup("dropped_key",  32'h66, 32'h0, 32'h0);

        // B: asynchronous reset while a write is pending.
        b_cmp_din = 32'h55;
        b_write(5'd2, 32'h99, 32'h0);
        check("mid_busy",  {31'b0, b_busy}, 32'h1);
        check("mid_match", {31'b0, b_match}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",  {31'b0, b_busy}, 32'h0);
        check("arst_match", {31'b0, b_match}, 32'h0);
        check("arst_vec",   {12'b0, b_match_addr}, 32'h0);
        check("arst_err",   {31'b0, b_wr_err}, 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        repeat (3) step();
        b_lookup("lost_write", 32'h99, 32'h0, 32'h0);
        b_lookup("valid_clr",  32'h55, 32'h0, 32'h0);

        // A: single entry, then multi-match.
        a_write(5'd3, 32'h0A00_0001, 32'h0);
        a_lookup("e3_hit",  32'h0A00_0001, 32'h0, 32'h0000_0008);
        a_lookup("e3_miss", 32'h0A00_0002, 32'h0, 32'h0);
        a_write(5'd5, 32'h0A00_0000, 32'h0000_00FF);
        a_lookup("multi",    32'h0A00_0001, 32'h0, 32'h0000_0028);
        a_lookup("key_mask", 32'hFF00_0001, 32'hFF00_0000, 32'h0000_0028);
        a_lookup("e5_only",  32'h0A00_00FF, 32'h0, 32'h0000_0020);

        // A: back-to-back writes on consecutive edges.
        a_we = 1'b1; a_wr_addr = 5'd7; a_din = 32'h11; a_dmask = 32'h0;
        step();
        check("b2b_busy0", {31'b0, a_busy}, 32'h0);
        m_data[7] = 32'h11; m_mask[7] = 32'h0; m_valid[7] = 1'b1;
        a_wr_addr = 5'd8; a_din = 32'h22;
        step();
        check("b2b_busy1", {31'b0, a_busy}, 32'h0);
        a_we = 1'b0;
        m_data[8] = 32'h22; m_mask[8] = 32'h0; m_valid[8] = 1'b1;
        a_lookup("b2b_e7", 32'h11, 32'h0, 32'h0000_0080);
        a_lookup("b2b_e8", 32'h22, 32'h0, 32'h0000_0100);
        check("b2b_err", {31'b0, a_wr_err}, 32'h0);

        // A: all-ones mask entry matches anything.
        a_write(5'd10, 32'h0, 32'hFFFF_FFFF);
        a_lookup("wild_only", 32'h1234_5678, 32'h0, 32'h0000_0400);
        a_lookup("wild_plus", 32'h11, 32'h0, 32'h0000_0480);

        // A: rewrite of a valid entry.
        a_write(5'd3, 32'h0B00_0000, 32'h0);
        a_lookup("rewr_old", 32'h0A00_0001, 32'h0, 32'h0000_0420);
        a_lookup("rewr_new", 32'h0B00_0000, 32'h0, 32'h0000_0408);

        // A: compare on the commit edge sees the old contents.
        a_we = 1'b1; a_wr_addr = 5'd12; a_din = 32'hCAFE_0000; a_dmask = 32'h0;
        a_cmp_din = 32'hCAFE_0000; a_cmp_mask = 32'h0;
        exp_q.push_back(32'h0000_0400);
        step();
        a_we = 1'b0;
        m_data[12] = 32'hCAFE_0000; m_mask[12] = 32'h0; m_valid[12] = 1'b1;
        a_pop_check("rdw_old");
        a_lookup("rdw_new", 32'hCAFE_0000, 32'h0, 32'h0000_1400);

        // A: random writes and lookups against the reference contents.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1)
                a_write(5'($urandom_range(0, 31)), 32'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0) ? 32'h3 : 32'h0);
            key   = 32'($urandom_range(0, 15));
            kmask = ($urandom_range(0, 3) == 0) ? 32'h3 : 32'h0;
            a_lookup("rand", key, kmask, model_vec(key, kmask));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unencoded_ternary_cam.md
Name: unencoded_ternary_cam

Overview:
- Register-based ternary CAM that serves as the responder on the CAM-side interface driven by the CAM/LUT lookup state machine in the output-port-lookup pcore.
- Holds DEPTH entries, each with compare data and a don't-care mask.
- Accepts single-entry writes with a busy handshake.
- Returns a registered, unencoded (one bit per entry) multi-match vector plus a global match flag, one cycle after the compare key is presented.

Parameters:
- CMP_WIDTH, 32, width of compare key, stored data and masks.
- DEPTH, 32, number of entries (need not be a power of 2).
- DEPTH_BITS, log2(DEPTH), width of wr_addr.
- WRITE_CYCLES, 1, cycles from write acceptance to commit (range 1..15).

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmp_din  in  CMP_WIDTH  compare key.
- cmp_data_mask  in  CMP_WIDTH  per-bit don't-care for the key (1 = ignore bit).
- din  in  CMP_WIDTH  entry data to write.
- data_mask  in  CMP_WIDTH  entry don't-care mask to write (1 = ignore bit).
- we  in  1  write strobe, sampled each edge.
- wr_addr  in  DEPTH_BITS  entry index to write.
- busy  out  1  write in progress; new writes are not accepted.
- match  out  1  OR of match_addr.
- match_addr  out  DEPTH  unencoded match vector; bit i = entry i matched.
- wr_err  out  1  sticky flag: a write was dropped.

Behaviour:
- Reset (async assert): valid[DEPTH-1:0]=0, match=0, match_addr=0, busy=0, wr_err=0, write counter=0, pending write discarded. Entry data/mask storage is not reset.
- Compare, every edge, no request input:
  - match_addr[i] <= valid[i] & &(~(stored_data[i] ^ cmp_din) | stored_mask[i] | cmp_data_mask).
  - match <= |next match_addr.
  - Latency: key at edge N -> result valid after edge N (visible cycle N+1).
  - Multiple hits all flag; no priority encoding here.
- Write acceptance at an edge when we=1, busy=0 and wr_addr<DEPTH:
  - Stage {wr_addr, din, data_mask}.
  - WRITE_CYCLES=1: commit at the same edge, busy never asserts, back-to-back writes on consecutive edges all accepted.
  - WRITE_CYCLES=W>1: busy=1 for the W-1 cycles after acceptance; commit (store data/mask, set valid[wr_addr]=1) at edge E0+W-1; busy drops at that same edge.
- Dropped writes:
  - we=1 while busy=1 -> dropped, wr_err <= 1.
  - wr_addr>=DEPTH -> dropped, wr_err <= 1.
  - wr_err clears only on reset.
- Read-during-write: a compare sampled on the commit edge sees the old contents and old valid of that entry. A compare at commit+1 sees the new contents.
- Rewrite of an already-valid entry replaces it; valid stays 1.
- An all-ones data_mask entry matches any key once valid.
- Reset mid-write: pending write lost, target entry keeps its previous contents; valid is cleared anyway.
- State: IDLE (counter=0) and WRITING (counter>0).
  - IDLE -> WRITING on acceptance when W>1.
  - WRITING -> IDLE at commit.

Decomposition:
- Shared package: log2 function, DEPTH/CMP_WIDTH defaults, WRITE_CYCLES range check constant.
- One sub-module, cam_entry_cmp: a single ternary entry compare (stored data, stored mask, valid, key, key mask -> hit). Instantiated DEPTH times via generate.

Test Plan:
- Reset, then key 0x0 with mask 0 -> match=0, match_addr=0 (all entries invalid); busy=0, wr_err=0.
- Write entry 3 = 0x0A000001, mask 0; then key 0x0A000001 -> match_addr=32'h00000008, match=1 one cycle later; key 0x0A000002 -> match=0.
- Entry 5 = 0x0A000000 with mask 0x000000FF, plus entry 3 as above; key 0x0A000001 -> match_addr=32'h00000028 (multi-match).
- Set WRITE_CYCLES=3; write entry 0, re-assert we on the next cycle -> busy=1 for 2 cycles, second write dropped, wr_err=1; compare on the commit edge misses, compare one cycle later hits.
- Set DEPTH=20; write with wr_addr=25 -> no entry changes, wr_err=1.
- Set WRITE_CYCLES=3; assert async reset mid-write (busy=1) -> busy, match and wr_err go 0 immediately; a subsequent compare for the written key misses.
